// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code.
// Register-exchange survivors; one decoded bit per accepted symbol.
module viterbi_decoder #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            code_valid,
    input  logic [1:0]      code_in,
    output logic            data_valid,
    output logic            data_out,
    output logic [PM_W-1:0] pm_best
);

    localparam int CW = $clog2(TB_DEPTH);
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(2 ** (PM_W - 2));
    localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};
    localparam logic [CW-1:0] CNT_LAST = CW'(TB_DEPTH - 1);

    logic [PM_W-1:0]     pm       [4];
    logic [PM_W-1:0]     pre      [4];
    logic [PM_W-1:0]     pm_nxt   [4];
    logic [PM_W:0]       cand0    [4];
    logic [PM_W:0]       cand1    [4];
    logic                sel      [4];
    logic [TB_DEPTH-1:0] path     [4];
    logic [TB_DEPTH-1:0] path_nxt [4];
    logic [PM_W-1:0]     pm_min;
    logic [1:0]          best;
    logic [CW-1:0]       cnt;

    // Metric of predecessor p plus Hamming distance of code c to the
    // symbol the encoder emits when input d leaves state p.
    function automatic logic [PM_W:0] cand(
        input logic [PM_W-1:0] m,
        input logic [1:0]      c,
        input logic [1:0]      p,
        input logic            d
    );
        logic [1:0] x;
        x = c ^ {d ^ p[1], d ^ p[0] ^ p[1]};
        return {1'b0, m} + (PM_W+1)'(x[0]) + (PM_W+1)'(x[1]);
    endfunction

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            logic [1:0] ns;
            logic [1:0] p0;
            logic [1:0] p1;
            logic [PM_W:0] raw;
            ns = 2'(n);
            p0 = {1'b0, ns[1]};
            p1 = {1'b1, ns[1]};
            cand0[n] = cand(pm[p0], code_in, p0, ns[0]);
            cand1[n] = cand(pm[p1], code_in, p1, ns[0]);
            sel[n] = cand1[n] < cand0[n];
            raw = sel[n] ? cand1[n] : cand0[n];
            pre[n] = (raw > PM_MAX) ? PM_MAX[PM_W-1:0] : raw[PM_W-1:0];
            path_nxt[n] = {path[sel[n] ? p1 : p0][TB_DEPTH-2:0], ns[0]};
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        pm_min = pre[0];
        best = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (pre[n] < pm_min) begin
                pm_min = pre[n];
                best = 2'(n);
            end
        end
        for (int n = 0; n < 4; n++) begin
            pm_nxt[n] = pre[n] - pm_min;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_valid <= 1'b0;
            data_out <= 1'b0;
            pm_best <= '0;
            cnt <= '0;
            pm[0] <= '0;
            for (int n = 1; n < 4; n++) pm[n] <= PM_INIT;
            for (int n = 0; n < 4; n++) path[n] <= '0;
        end else if (code_valid) begin
            data_valid <= (cnt == CNT_LAST);
            data_out <= path_nxt[best][TB_DEPTH-1];
            pm_best <= pm_min;
            if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
            for (int n = 0; n < 4; n++) begin
                pm[n] <= pm_nxt[n];
                path[n] <= path_nxt[n];
            end
        end else begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed and model-checked bench for viterbi_decoder.
// Hand-computed clean/error/gap/reset vectors plus a long noisy run.
module tb_viterbi_decoder;

    localparam int TB = 16;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          code_valid = 1'b0;
    logic [1:0]    code_in = 2'b00;
    logic          data_valid;
    logic          data_out;
    logic [PW-1:0] pm_best;

    viterbi_decoder #(.TB_DEPTH(TB), .PM_W(PW)) dut (
        .clk(clk),
        .reset(reset),
        .code_valid(code_valid),
        .code_in(code_in),
        .data_valid(data_valid),
        .data_out(data_out),
        .pm_best(pm_best)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int n_acc, first, pulses, ones, max_pm, pm_at1;
    logic bits[$];
    logic [1:0] clean [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};

    int mpm [4];
    int mdec [64][4];
    int mj;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        @(negedge clk);
        code_valid = v;
        code_in = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        code_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_do", 32'(data_out), 0);
        chk("rst_pm", 32'(pm_best), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_stats();
        n_acc = 0;
        first = 0;
        pulses = 0;
        ones = 0;
        max_pm = 0;
        pm_at1 = -1;
        bits.delete();
    endtask

    task automatic feed(input logic [1:0] s, input int gap);
        logic [PW:0] held;
        step(1'b1, s);
        n_acc++;
        if (int'(pm_best) > max_pm) max_pm = int'(pm_best);
        if (data_valid) begin
            pulses++;
            if (first == 0) first = n_acc;
            if (data_out) ones++;
            bits.push_back(data_out);
        end
        for (int g = 0; g < gap; g++) begin
            held = {data_out, pm_best};
            step(1'b0, 2'b11);
            chk("gap_dv", 32'(data_valid), 0);
            chk("gap_hold", 32'({data_out, pm_best}), 32'(held));
        end
    endtask

    task automatic run_clean(input int n, input int gap, input bit corrupt);
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin
            s = (i < 6) ? clean[i] : 2'b00;
            if (corrupt && i == 1) s = 2'b11;
            feed(s, gap);
            if (i == 1) pm_at1 = int'(pm_best);
        end
    endtask

    task automatic chk_bits(input string tag);
        logic [5:0] got;
        for (int k = 0; k < 6; k++)
            got[5-k] = (k < bits.size()) ? bits[k] : 1'bx;
        chk(tag, 32'(got), 32'b101100);
    endtask

    function automatic logic [1:0] enc(input int p, input int d);
        logic s0, s1, b;
        s0 = p[0];
        s1 = p[1];
        b = d[0];
        return {b ^ s1, b ^ s0 ^ s1};
    endfunction

    task automatic m_reset();
        mpm = '{0, 2 ** (PW - 2), 2 ** (PW - 2), 2 ** (PW - 2)};
        mj = 0;
    endtask

    // Reference: full decision history with explicit traceback.
    task automatic m_step(input logic [1:0] s, output logic edv,
                          output logic edo, output int epm);
        int pre [4];
        int ca, cb, mn, bst, st;
        for (int n = 0; n < 4; n++) begin
            ca = mpm[n >> 1] + $countones(s ^ enc(n >> 1, n & 1));
            cb = mpm[2 + (n >> 1)] + $countones(s ^ enc(2 + (n >> 1), n & 1));
            mdec[mj % 64][n] = (cb < ca) ? 1 : 0;
            pre[n] = (cb < ca) ? cb : ca;
            if (pre[n] > 2 ** PW - 1) pre[n] = 2 ** PW - 1;
        end
        mn = pre[0];
        bst = 0;
        for (int n = 1; n < 4; n++)
            if (pre[n] < mn) begin
                mn = pre[n];
                bst = n;
            end
        for (int n = 0; n < 4; n++) mpm[n] = pre[n] - mn;
        epm = mn;
        edv = (mj >= TB - 1);
        edo = 1'b0;
        if (edv) begin
            st = bst;
            for (int k = 0; k < TB - 1; k++)
                st = mdec[(mj - k) % 64][st] * 2 + (st >> 1);
            edo = st[0];
        end
        mj++;
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s, err;
        logic edv, edo;
        int epm, es, d;

        do_reset();

        clear_stats();
        for (int i = 0; i < 40; i++) feed(2'b00, 0);
        chk("zero_first", 32'(first), 16);
        chk("zero_pulses", 32'(pulses), 25);
        chk("zero_ones", 32'(ones), 0);
        chk("zero_maxpm", 32'(max_pm), 0);

        do_reset();
        clear_stats();
        run_clean(22, 0, 1'b0);
        chk("clean_first", 32'(first), 16);
        chk_bits("clean_bits");
        chk("clean_pm", 32'(max_pm), 0);

        do_reset();
        clear_stats();
        run_clean(22, 0, 1'b1);
        chk("err_pm1", 32'(pm_at1), 1);
        chk("err_first", 32'(first), 16);
        chk_bits("err_bits");

        do_reset();
        clear_stats();
        run_clean(22, 3, 1'b0);
        chk("gap_first", 32'(first), 16);
        chk_bits("gap_bits");

        do_reset();
        clear_stats();
        run_clean(10, 0, 1'b0);
        do_reset();
        clear_stats();
        run_clean(22, 0, 1'b0);
        chk("rstmid_first", 32'(first), 16);
        chk_bits("rstmid_bits");

        do_reset();
        m_reset();
        es = 0;
        for (int i = 0; i < 10000; i++) begin
            d = int'($urandom_range(0, 1));
            s = enc(es, d);
            es = ((es & 1) << 1) | d;
            err = ($urandom_range(0, 7) == 0) ?
                  (2'b01 << $urandom_range(0, 1)) : 2'b00;
            s = s ^ err;
            m_step(s, edv, edo, epm);
            step(1'b1, s);
            chk("noisy_dv", 32'(data_valid), 32'(edv));
            if (edv) chk("noisy_do", 32'(data_out), 32'(edo));
            chk("noisy_pm", 32'(pm_best), 32'(epm));
            chk("noisy_bound", 32'(int'(pm_best) <= 2 ** (PW - 1)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
